// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4 shared definitions.
// Slot geometry and FSM states, also used by the transmit-side sequencer.
package tdm_demux4_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;
  localparam int DEF_W  = 2;

  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(SLOTS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// tdm_demux4 slot counter.
// Clear, load-to-1 and wrapping increment of the slot index.
module tdm_demux4_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] s,
  output logic              last
);

  // Slot index: clear beats load, load beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (clr) begin
      s <= '0;
    end else if (load1) begin
      s <= SLOT_W'(1);
    end else if (inc) begin
      s <= s + SLOT_W'(1);
    end
  end

  assign last = (s == SLOT_LAST);

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4 top: TDM receiver with frame-sync alignment.
// Shadow bank collects slots 0..2; slot 3 commits all four at once.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic         VALID,
  input  logic         SYNC,
  input  logic [W-1:0] DIN,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic [1:0]   S,
  output logic         LOCKED,
  output logic         FRAME_VLD,
  output logic         SYNC_ERR
);

  state_t              state;
  logic [W-1:0]        sh0;
  logic [W-1:0]        sh1;
  logic [W-1:0]        sh2;
  logic [SLOT_W-1:0]   s_q;
  logic                last;
  logic                beat;
  logic                run;
  logic                resync;
  logic                acq;
  logic                ld1;
  logic                inc;

  assign run    = (state == ST_RUN);
  assign beat   = EN & VALID;
  assign acq    = beat & SYNC & ~run;
  assign resync = beat & SYNC & run & (s_q != '0);
  assign ld1    = acq | resync;
  assign inc    = beat & run & ~resync;

  tdm_demux4_slot_ctr u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (~EN),
    .load1 (ld1),
    .inc   (inc),
    .s     (s_q),
    .last  (last)
  );

  assign S      = s_q;
  assign LOCKED = run;

  // FSM, shadow bank, output registers and pulse flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sh0       <= '0;
      sh1       <= '0;
      sh2       <= '0;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      FRAME_VLD <= 1'b0;
      SYNC_ERR  <= 1'b0;
    end else begin
      FRAME_VLD <= 1'b0;
      SYNC_ERR  <= 1'b0;
      if (!EN) begin
        state <= ST_IDLE;
      end else if (ld1) begin
        state    <= ST_RUN;
        sh0      <= DIN;
        SYNC_ERR <= resync;
      end else if (inc) begin
        unique case (s_q)
          2'd0: sh0 <= DIN;
          2'd1: sh1 <= DIN;
          2'd2: sh2 <= DIN;
          2'd3: begin
            A         <= sh0;
            B         <= sh1;
            C         <= sh2;
            D         <= DIN;
            FRAME_VLD <= 1'b1;
          end
        endcase
      end
    end
  end

  logic unused_last;
  assign unused_last = last;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed tests for the TDM demultiplexer.
// Each task drives one scenario and checks against hand-computed values.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       EN;
  logic       VALID;
  logic       SYNC;
  logic [1:0] DIN;
  logic [1:0] A, B, C, D, S;
  logic       LOCKED, FRAME_VLD, SYNC_ERR;

  int n_cmp = 0;
  int n_bad = 0;
  int fv;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .VALID     (VALID),
    .SYNC      (SYNC),
    .DIN       (DIN),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .S         (S),
    .LOCKED    (LOCKED),
    .FRAME_VLD (FRAME_VLD),
    .SYNC_ERR  (SYNC_ERR)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic sy);
    VALID = 1'b1;
    SYNC  = sy;
    DIN   = d;
    tick();
    VALID = 1'b0;
    SYNC  = 1'b0;
    if (FRAME_VLD) fv++;
  endtask

  task automatic test_reset();
    rst = 1'b1; EN = 1'b0; VALID = 1'b0; SYNC = 1'b0; DIN = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({A, B, C, D, S, LOCKED, FRAME_VLD, SYNC_ERR} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset: got %b want 0",
        {A, B, C, D, S, LOCKED, FRAME_VLD, SYNC_ERR});
    end
  endtask

  task automatic test_basic_frame();
    EN = 1'b1;
    fv = 0;
    send(2'd0, 1'b1);
    n_cmp++;
    if ({LOCKED, S} !== 3'b1_01) begin
      n_bad++;
      $display("FAIL lock: got L=%b S=%0d want L=1 S=1", LOCKED, S);
    end
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    n_cmp++;
    if ({A, B, C, D} !== 8'b00_01_10_11) begin
      n_bad++;
      $display("FAIL basic_abcd: got %h want 1b", {A, B, C, D});
    end
    n_cmp++;
    if ({FRAME_VLD, LOCKED, S} !== 4'b1_1_00 || fv !== 1) begin
      n_bad++;
      $display("FAIL basic_flags: got FV=%b L=%b S=%0d n=%0d want 1 1 0 1",
        FRAME_VLD, LOCKED, S, fv);
    end
    tick();
    n_cmp++;
    if (FRAME_VLD !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse: got FV=%b want 0", FRAME_VLD);
    end
  endtask

  task automatic test_gapped();
    logic [1:0] exp_s;
    int         s_bad;
    fv = 0;
    s_bad = 0;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), i == 0);
      exp_s = 2'(i + 1);
      for (int g = 0; g < 2; g++) begin
        tick();
        if (FRAME_VLD) fv++;
        if (S !== exp_s) s_bad++;
      end
    end
    n_cmp++;
    if (s_bad !== 0) begin
      n_bad++;
      $display("FAIL gap_s_hold: got %0d bad gap cycles want 0", s_bad);
    end
    n_cmp++;
    if ({A, B, C, D} !== 8'b00_01_10_11 || fv !== 1) begin
      n_bad++;
      $display("FAIL gap_frame: got %h n=%0d want 1b n=1",
        {A, B, C, D}, fv);
    end
  endtask

  task automatic test_presync();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd3, 1'b0);
    n_cmp++;
    if ({A, B, C, D, LOCKED, S} !== 11'd0) begin
      n_bad++;
      $display("FAIL presync_drop: got %b want 0", {A, B, C, D, LOCKED, S});
    end
    send(2'd2, 1'b1);
    send(2'd2, 1'b0);
    send(2'd1, 1'b0);
    n_cmp++;
    if ({A, B, C, D} !== 8'd0) begin
      n_bad++;
      $display("FAIL presync_hold: got %h want 00", {A, B, C, D});
    end
    send(2'd0, 1'b0);
    n_cmp++;
    if ({A, B, C, D, FRAME_VLD} !== 9'b10_10_01_00_1) begin
      n_bad++;
      $display("FAIL presync_frame: got %b want 101001001",
        {A, B, C, D, FRAME_VLD});
    end
  endtask

  task automatic test_misaligned();
    send(2'd3, 1'b1);
    send(2'd3, 1'b0);
    send(2'd1, 1'b1);
    n_cmp++;
    if ({SYNC_ERR, FRAME_VLD, S, LOCKED} !== 5'b1_0_01_1) begin
      n_bad++;
      $display("FAIL resync_flags: got E=%b FV=%b S=%0d L=%b want 1 0 1 1",
        SYNC_ERR, FRAME_VLD, S, LOCKED);
    end
    n_cmp++;
    if ({A, B, C, D} !== 8'b10_10_01_00) begin
      n_bad++;
      $display("FAIL resync_hold: got %h want a4", {A, B, C, D});
    end
    tick();
    n_cmp++;
    if (SYNC_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL resync_pulse: got %b want 0", SYNC_ERR);
    end
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    send(2'd0, 1'b0);
    n_cmp++;
    if ({A, B, C, D, FRAME_VLD, SYNC_ERR} !== 10'b01_10_11_00_1_0) begin
      n_bad++;
      $display("FAIL resync_frame: got %b want 0110110010",
        {A, B, C, D, FRAME_VLD, SYNC_ERR});
    end
  endtask

  task automatic test_en_drop();
    send(2'd0, 1'b1);
    send(2'd1, 1'b0);
    EN = 1'b0;
    tick();
    n_cmp++;
    if ({LOCKED, S, A, B, C, D} !== 11'b0_00_01_10_11_00) begin
      n_bad++;
      $display("FAIL en_drop: got %b want 00001101100",
        {LOCKED, S, A, B, C, D});
    end
    send(2'd3, 1'b1);
    n_cmp++;
    if ({LOCKED, S} !== 3'b0) begin
      n_bad++;
      $display("FAIL en_ignore: got L=%b S=%0d want 0 0", LOCKED, S);
    end
    EN = 1'b1;
    fv = 0;
    send(2'd3, 1'b1);
    send(2'd2, 1'b0);
    send(2'd1, 1'b0);
    n_cmp++;
    if (fv !== 0 || LOCKED !== 1'b1) begin
      n_bad++;
      $display("FAIL en_relock: got n=%0d L=%b want 0 1", fv, LOCKED);
    end
    send(2'd0, 1'b0);
    n_cmp++;
    if ({A, B, C, D, FRAME_VLD} !== 9'b11_10_01_00_1) begin
      n_bad++;
      $display("FAIL en_frame: got %b want 111001001",
        {A, B, C, D, FRAME_VLD});
    end
  endtask

  task automatic test_rst_mid_frame();
    send(2'd3, 1'b1);
    for (int i = 0; i < 3; i++) send(2'd3, 1'b0);
    n_cmp++;
    if ({A, B, C, D} !== 8'hff) begin
      n_bad++;
      $display("FAIL rst_setup: got %h want ff", {A, B, C, D});
    end
    send(2'd1, 1'b1);
    send(2'd1, 1'b0);
    rst = 1'b1; VALID = 1'b1; SYNC = 1'b1; DIN = 2'd2;
    tick();
    rst = 1'b0; VALID = 1'b0; SYNC = 1'b0;
    n_cmp++;
    if ({A, B, C, D, S, LOCKED, FRAME_VLD, SYNC_ERR} !== 13'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got %b want 0",
        {A, B, C, D, S, LOCKED, FRAME_VLD, SYNC_ERR});
    end
    send(2'd1, 1'b1);
    send(2'd0, 1'b0);
    send(2'd3, 1'b0);
    send(2'd2, 1'b0);
    n_cmp++;
    if ({A, B, C, D, FRAME_VLD} !== 9'b01_00_11_10_1) begin
      n_bad++;
      $display("FAIL rst_after: got %b want 010011101",
        {A, B, C, D, FRAME_VLD});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gapped();
    test_presync();
    test_misaligned();
    test_en_drop();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receiving end of the team's 4-to-1 selector path: a time-division demultiplexer. It takes a stream of W-bit samples that the transmit side sends one slot at a time, selected in order 0,1,2,3. It recovers slot alignment from a frame-sync marker and distributes each sample to one of four channel outputs. The four outputs update together once per complete frame.

## Interface
- W, default 2: sample width in bits; matches the A/B/C/D width of the selector.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- EN  in  1  block enable; low = idle and discard partial frame.
- VALID  in  1  DIN/SYNC carry a sample this cycle.
- SYNC  in  1  qualified by VALID; marks this beat as slot 0.
- DIN  in  W  incoming sample.
- A  out  W  channel 0 (slot 0) output, registered.
- B  out  W  channel 1 (slot 1) output, registered.
- C  out  W  channel 2 (slot 2) output, registered.
- D  out  W  channel 3 (slot 3) output, registered.
- S  out  2  slot index expected on the next VALID beat.
- LOCKED  out  1  high while in RUN state.
- FRAME_VLD  out  1  one-cycle pulse; A..D just updated with a full frame.
- SYNC_ERR  out  1  one-cycle pulse; SYNC seen at a slot other than 0 while in RUN.

## Operation
- States: IDLE and RUN.
- IDLE behaviour:
  - Wait for a beat with EN=1 and VALID=1 and SYNC=1.
  - On that beat, capture DIN into shadow[0], set S=1, go to RUN.
  - VALID beats without SYNC are dropped.
- RUN behaviour:
  - Each beat with EN=1 and VALID=1 captures DIN into shadow[S], then S increments mod 4.
  - The beat with S=3 copies shadow[0..2] plus that beat's DIN into A..D in one edge, pulses FRAME_VLD, and wraps S to 0.
- Resync:
  - In RUN, a beat with VALID=1, SYNC=1 and S≠0 pulses SYNC_ERR.
  - The partial frame is discarded; A..D are not updated.
  - That beat is taken as slot 0: shadow[0]=DIN, S=1.
  - SYNC at S=0 is the normal case, not an error.
- SYNC=0 at S=0 in RUN is accepted. Lock is kept; the frame alignment is trusted.
- VALID=0 cycles: no state change (gaps between slots are allowed).
- EN=0 behaviour:
  - Return to IDLE next edge and set S=0.
  - Shadow contents are don't-care.
  - A..D hold their last complete-frame values.
  - Inputs are ignored.
- Priority when several conditions hold: rst > EN=0 > resync > normal capture.

## Timing
- Reset values:
  - State IDLE.
  - S=0, LOCKED=0, FRAME_VLD=0, SYNC_ERR=0.
  - A=B=C=D=0; shadow registers cleared.
- rst mid-frame: reset values apply on the next edge and the partial frame is lost. An asserted SYNC in the reset cycle is ignored.
- Latency: A..D, FRAME_VLD and the new S value are all visible one cycle after the slot-3 beat's clock edge.
- With back-to-back VALID, FRAME_VLD pulses once every 4 cycles.
- LOCKED behaviour:
  - Rises one cycle after the accepted SYNC beat in IDLE.
  - Falls one cycle after EN drops.
  - Stays high through a resync.
- SYNC_ERR is registered and appears one cycle after the offending beat. It never coincides with FRAME_VLD for the same beat.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package header (tdm_defs.vh):
  - Slot count 4.
  - Slot index width 2.
  - State encodings ST_IDLE and ST_RUN.
  - Default sample width 2.
  - The transmit-side 4-to-1 sequencer uses the same header.
- One natural sub-module: tdm_slot_ctr, the 2-bit slot counter with load-to-1, wrap and clear. It outputs S and the "last slot" flag.
- The top level holds the FSM, the shadow bank, the output registers and the pulse flops.

## Test plan
- Lock and basic frame:
  - Stimulus: reset, EN=1, continuous VALID, DIN sequence 0,1,2,3 with SYNC on the first beat.
  - Required: one cycle after the 4th beat, A=0, B=1, C=2, D=3, FRAME_VLD pulses once, LOCKED=1, S=0.
- Gapped input:
  - Stimulus: same frame as above with VALID low for 2 cycles between each beat.
  - Required: identical A..D; FRAME_VLD pulses exactly once; S holds during the gaps.
- Pre-sync rejection:
  - Stimulus: in IDLE, send DIN=3 with VALID and no SYNC for 3 beats, then a synced frame 2,2,1,0.
  - Required: A..D stay 0 until that frame completes, then become 2,2,1,0.
- Misaligned SYNC:
  - Stimulus: while locked, assert SYNC at S=2 with DIN=1, followed by DIN 2,3,0.
  - Required: SYNC_ERR pulses one cycle later; A..D keep the previous frame; then A=1, B=2, C=3, D=0 with FRAME_VLD.
- EN drop mid-frame:
  - Stimulus: while locked, drop EN after 2 beats of a frame, then restore EN with a new synced frame.
  - Required: LOCKED falls; S=0; A..D unchanged; no FRAME_VLD until the new frame completes.
- Reset mid-frame:
  - Stimulus: while locked with outputs A..D=3, assert rst for 1 cycle at S=2.
  - Required: next cycle all outputs are 0 and the state is IDLE; the next synced frame decodes correctly.
